// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexed 7-segment display scanner. Cycles an
//               active-low anode through N_DIGITS digits, one slot of
//               SCAN_DIV clocks each, with a DEAD_CYC all-off guard at the
//               start of every slot. Decodes hex nibbles to active-low
//               cathodes and supports per-digit blanking, blinking, decimal
//               point and leading-zero suppression.
//
// Ports       : clk         - sole clock, rising edge
//               rst_n       - synchronous active-low reset
//               digits      - 4*N_DIGITS, nibble i drives digit i (0 = right)
//               dp          - per-digit decimal-point request, active-high
//               blink_en    - per-digit blink enable
//               blank       - per-digit force-off
//               lz_suppress - leading-zero suppression enable
//               seg         - cathodes a..g (bit0..bit6), active-low, registered
//               dp_n        - decimal-point cathode, active-low, registered
//               an          - anodes, active-low, at most one low, registered
//               frame_tick  - one-cycle pulse as the scan wraps to digit 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int DEAD_CYC  = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blink_en,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW = $clog2(N_DIGITS);
    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0] c_DEAD       = c_PW'(DEAD_CYC);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(N_DIGITS - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
    localparam logic [6:0]      c_SEG_OFF    = 7'h7F;

    // Scan / blink state
    logic [c_PW-1:0]     r_presc;
    logic [c_IW-1:0]     r_idx;
    logic [c_BW-1:0]     r_blink_cnt;
    logic                r_blink_phase;

    // Output registers
    logic [6:0]          r_seg;
    logic                r_dp_n;
    logic [N_DIGITS-1:0] r_an;
    logic                r_frame_tick;

    // Combinational helpers
    logic                w_presc_wrap;
    logic                w_idx_wrap;
    logic                w_blink_wrap;
    logic                w_dead;
    logic                w_lz_sup;
    logic                w_sup;
    logic [3:0]          w_nibble;
    logic [N_DIGITS-1:0] w_upper_zero;
    logic [N_DIGITS-1:0] w_an_act;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'h0:    f_decode = 7'h40;
            4'h1:    f_decode = 7'h79;
            4'h2:    f_decode = 7'h24;
            4'h3:    f_decode = 7'h30;
            4'h4:    f_decode = 7'h19;
            4'h5:    f_decode = 7'h12;
            4'h6:    f_decode = 7'h02;
            4'h7:    f_decode = 7'h78;
            4'h8:    f_decode = 7'h00;
            4'h9:    f_decode = 7'h10;
            4'hA:    f_decode = 7'h08;
            4'hB:    f_decode = 7'h03;
            4'hC:    f_decode = 7'h46;
            4'hD:    f_decode = 7'h21;
            4'hE:    f_decode = 7'h06;
            default: f_decode = 7'h0E;
        endcase
    endfunction

    assign w_presc_wrap = (r_presc == c_PRESC_LAST);
    assign w_idx_wrap   = (r_idx == c_IDX_LAST);
    assign w_blink_wrap = (r_blink_cnt == c_BLINK_LAST);
    assign w_dead       = (r_presc < c_DEAD);
    // {idx,2'b00} is 4*idx without a 32-bit multiply
    assign w_nibble     = digits[{r_idx, 2'b00} +: 4];

    // w_upper_zero[i] is set when nibbles i..N_DIGITS-1 are all zero,
    // built as a chain from the most significant digit downward.
    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[N_DIGITS-1] = (digits[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            w_upper_zero[i] = (digits[4*i +: 4] == 4'h0) && w_upper_zero[i+1];
        end
    end

    // Digit 0 is exempt so an all-zero value still shows a single "0".
    assign w_lz_sup = lz_suppress && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_sup    = blank[r_idx] || (blink_en[r_idx] && r_blink_phase) || w_lz_sup;

    always_comb begin
        w_an_act        = '1;
        w_an_act[r_idx] = 1'b0;
    end

    // Outputs are registered from the current scan state, so each output
    // cycle shows the slot position the counters held one edge earlier.
    // Cathodes are also turned off in the dead phase so no stale pattern
    // is present when the next anode switches on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= '1;
            r_seg         <= c_SEG_OFF;
            r_dp_n        <= 1'b1;
            r_frame_tick  <= 1'b0;
        end else begin
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_idx   <= w_idx_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (w_dead || w_sup) begin
                r_an   <= '1;
                r_seg  <= c_SEG_OFF;
                r_dp_n <= 1'b1;
            end else begin
                r_an   <= w_an_act;
                r_seg  <= f_decode(w_nibble);
                r_dp_n <= ~dp[r_idx];
            end

            r_frame_tick <= w_presc_wrap && w_idx_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
